// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: groups the control-side request signals and the
// register-file writeback signals of the multiply/divide unit.
//
// Signals:
//   start, op, operand_a, operand_b, dest_addr  - request from control
//   busy, done, div_by_zero                     - status back to control
//   wb_enable, wb_addr, wb_data                 - register-file write port
//
// Modports:
//   master - the control/testbench side that issues requests
//   slave  - the execution unit itself
interface mul_div_unit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [2:0]       dest_addr;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic             wb_enable;
    logic [2:0]       wb_addr;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output start, op, operand_a, operand_b, dest_addr,
        input  busy, done, div_by_zero, wb_enable, wb_addr, wb_data
    );

    modport slave (
        input  start, op, operand_a, operand_b, dest_addr,
        output busy, done, div_by_zero, wb_enable, wb_addr, wb_data
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle unsigned multiply (shift-add) and divide
// (restoring) unit. A request is accepted in IDLE, iterates ITER cycles,
// then writes the two result bytes through the register-file write port:
// low byte / quotient to rd, high byte / remainder to rd+1 (mod 8).
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous, active-high reset
//   bus  - mul_div_unit_if.slave: request, status and writeback signals
//
// Parameters:
//   WIDTH - operand width (8 only)
//   ITER  - iteration count, equal to WIDTH
module mul_div_unit #(
    parameter int WIDTH = 8,
    parameter int ITER  = 8
) (
    input logic          clk,
    input logic          rst,
    mul_div_unit_if.slave bus
);
    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WB_LO,
        WB_HI
    } state_t;

    state_t           state;
    state_t           next_state;

    logic             op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dbz_q;
    // hi_q: running product high half / partial remainder.
    // lo_q: multiplier being consumed (becomes product low half) /
    //       dividend being consumed (becomes quotient).
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign accept    = (state == IDLE) && bus.start;
    assign last_iter = (cnt_q == CNT_W'(ITER - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = CALC;
            CALC:    if (last_iter) next_state = WB_LO;
            WB_LO:   next_state = WB_HI;
            WB_HI:   next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration step of each algorithm.
    // The divide shift is 9 bits wide; when its top bit is set the shifted
    // remainder is certainly >= the divisor, and the 8-bit difference is
    // exact because the true remainder always stays below the divisor.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift[WIDTH] || (div_shift[WIDTH-1:0] >= b_q);
        div_diff  = div_shift[WIDTH-1:0] - b_q;
    end

    // Operand latch and iteration datapath. Requests arriving outside IDLE
    // never touch the latched operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            dbz_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (accept) begin
            op_q  <= bus.op;
            a_q   <= bus.operand_a;
            b_q   <= bus.operand_b;
            rd_q  <= bus.dest_addr;
            cnt_q <= '0;
            dbz_q <= bus.op && (bus.operand_b == '0);
            hi_q  <= '0;
            lo_q  <= bus.op ? bus.operand_a : bus.operand_b;
        end else if (state == CALC) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (op_q) begin
                hi_q <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                lo_q <= {lo_q[WIDTH-2:0], div_ge};
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    // Outputs decoded from the state register and latched result only.
    // Divide by zero forces Q to all ones and R to the dividend.
    always_comb begin
        bus.busy      = (state != IDLE);
        bus.done      = (state == WB_HI);
        bus.wb_enable = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        case (state)
            WB_LO: begin
                bus.wb_enable = 1'b1;
                bus.wb_addr   = rd_q;
                bus.wb_data   = dbz_q ? {WIDTH{1'b1}} : lo_q;
            end
            WB_HI: begin
                bus.wb_enable = 1'b1;
                bus.wb_addr   = rd_q + 3'd1;
                bus.wb_data   = dbz_q ? a_q : hi_q;
            end
            default: ;
        endcase
    end

    assign bus.div_by_zero = dbz_q;

endmodule
